// File: rtl/noc_link_tx_pkg.sv
// Shared types and defaults for the NoC link transmitter.
package noc_link_tx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } state_e;

  localparam int LEN_LSB     = 0;
  localparam int DEF_LEN_W   = 6;
  localparam int DEF_FLIT_W  = 32;
  localparam int DEF_CREDITS = 4;
  localparam int DEF_CRED_W  = 3;

endpackage

// File: rtl/noc_link_tx_if.sv
// Flit link bundle: upstream handshake plus downstream
// flit strobe and credit return.
interface noc_link_tx_if
  import noc_link_tx_pkg::*;
#(
  parameter int FLIT_W = DEF_FLIT_W
);
  logic [FLIT_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid;
  logic              out_head;
  logic              out_tail;
  logic              credit_ret;

  modport slave (
    input  in_flit, in_valid, credit_ret,
    output in_ready, out_flit, out_valid,
    output out_head, out_tail
  );

  modport master (
    output in_flit, in_valid, credit_ret,
    input  in_ready, out_flit, out_valid,
    input  out_head, out_tail
  );
endinterface

// File: rtl/noc_link_tx_flit_counter.sv
// Loadable down-counter holding the remaining body flits
// of the packet in flight.
module tx_flit_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_rem,
  output logic         o_rem_is_one,
  output logic         o_rem_is_zero
);

  logic [W-1:0] r_rem;

  // Decrement stops at zero so rem can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
    end else if (i_load) begin
      r_rem <= i_load_val;
    end else if (i_dec && (r_rem != '0)) begin
      r_rem <= r_rem - 1'b1;
    end
  end

  assign o_rem         = r_rem;
  assign o_rem_is_one  = (r_rem == W'(1));
  assign o_rem_is_zero = (r_rem == '0);

endmodule

// File: rtl/noc_link_tx.sv
// Credit-based link transmitter: frames flits into packets
// by header length and never sends without a far-side slot.
module noc_link_tx
  import noc_link_tx_pkg::*;
#(
  parameter int FLIT_W  = DEF_FLIT_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CREDITS = DEF_CREDITS,
  parameter int CRED_W  = DEF_CRED_W
) (
  input  logic              clk,
  input  logic              rst,
  noc_link_tx_if.slave      lnk,
  output logic [CRED_W-1:0] credit_cnt,
  output logic              busy,
  output logic              err_overflow
);

  localparam logic [CRED_W-1:0] CRED_MAX =
    CRED_W'(CREDITS);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CRED_W-1:0] r_credit;
  logic              r_err;
  logic [FLIT_W-1:0] r_out_flit;
  logic              r_out_valid;
  logic              r_out_head;
  logic              r_out_tail;

  logic              w_xfer;
  logic [LEN_W-1:0]  w_len;
  logic              w_load;
  logic              w_dec;
  logic              w_head;
  logic              w_tail;
  logic [LEN_W-1:0]  w_rem;
  logic              w_rem_one;
  logic              w_rem_zero;

  assign lnk.in_ready = (r_credit != '0);
  assign w_xfer = lnk.in_valid && lnk.in_ready;
  assign w_len  = lnk.in_flit[LEN_LSB +: LEN_W];

  tx_flit_counter #(
    .W (LEN_W)
  ) u_cnt (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_load_val    (w_len),
    .i_dec         (w_dec),
    .o_rem         (w_rem),
    .o_rem_is_one  (w_rem_one),
    .o_rem_is_zero (w_rem_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_head      = 1'b0;
    w_tail      = 1'b0;
    if (w_xfer) begin
      unique case (r_state)
        ST_IDLE: begin
          w_head = 1'b1;
          if (w_len == '0) begin
            w_tail = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_BODY;
          end
        end
        ST_BODY: begin
          w_dec = 1'b1;
          if (w_rem_one) begin
            w_tail      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // A send and a return in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit <= CRED_MAX;
      r_err    <= 1'b0;
    end else begin
      case ({w_xfer, lnk.credit_ret})
        2'b10: r_credit <= r_credit - 1'b1;
        2'b01: begin
          if (r_credit == CRED_MAX) begin
            r_err <= 1'b1;
          end else begin
            r_credit <= r_credit + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_flit  <= '0;
      r_out_valid <= 1'b0;
      r_out_head  <= 1'b0;
      r_out_tail  <= 1'b0;
    end else begin
      r_out_valid <= w_xfer;
      r_out_head  <= w_head;
      r_out_tail  <= w_tail;
      if (w_xfer) begin
        r_out_flit <= lnk.in_flit;
      end
    end
  end

  assign lnk.out_flit  = r_out_flit;
  assign lnk.out_valid = r_out_valid;
  assign lnk.out_head  = r_out_head;
  assign lnk.out_tail  = r_out_tail;
  assign credit_cnt    = r_credit;
  assign busy          = (r_state == ST_BODY);
  assign err_overflow  = r_err;

  logic w_unused;
  assign w_unused = ^{w_rem, w_rem_zero};

endmodule
